// File: rtl/rv3n_func_div.sv
// Iterative RV32M divide unit (DIV/DIVU/REM/REMU) for one FUNC slot.
// Restoring division at one quotient bit per cycle, with fast paths for divide-by-zero and signed overflow.
module rv3n_func_div #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            calc_valid,
  input  logic [7:0]      calc_para,
  input  logic [XLEN-1:0] calc_operand0,
  input  logic [XLEN-1:0] calc_operand1,
  input  logic            calc_flush,
  output logic            calc_busy,
  output logic            calc_done,
  output logic [XLEN-1:0] calc_result
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  dvd;      // dividend shifts out, quotient bits shift in
  logic [XLEN-1:0]  dvs;
  logic [XLEN-1:0]  rem;
  logic             rem_sel, neg_q, neg_r;

  logic             accept, sign0, sign1, div_zero, ovf, fast;
  logic [XLEN-1:0]  abs0, abs1, fast_result;
  logic [XLEN:0]    rem_sh, rem_sub;
  logic             rem_ge;
  logic [XLEN-1:0]  rem_new, dvd_new, q_fix, r_fix, fin_result;
  logic             unused_para;

  assign unused_para = ^calc_para[7:3];

  // NOTE: combinational blocks assign every output a default first, so no path can infer a latch.
  always_comb begin
    accept    = (state == IDLE) && calc_valid && calc_para[2] && !calc_flush;
    sign0     = !calc_para[0] && calc_operand0[XLEN-1];
    sign1     = !calc_para[0] && calc_operand1[XLEN-1];
    abs0      = sign0 ? -calc_operand0 : calc_operand0;
    abs1      = sign1 ? -calc_operand1 : calc_operand1;
    div_zero  = (calc_operand1 == '0);
    ovf       = !calc_para[0] && (calc_operand0 == INT_MIN) && (calc_operand1 == '1);
    fast      = div_zero || ovf;
    if (div_zero) fast_result = calc_para[1] ? calc_operand0 : '1;
    else          fast_result = calc_para[1] ? '0 : INT_MIN;

    // Shifted remainder carries XLEN+1 bits so a large unsigned divisor never overflows the compare.
    rem_sh     = {rem, dvd[XLEN-1]};
    rem_sub    = rem_sh - {1'b0, dvs};
    rem_ge     = (rem_sh >= {1'b0, dvs});
    rem_new    = rem_ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
    dvd_new    = {dvd[XLEN-2:0], rem_ge};
    q_fix      = neg_q ? -dvd_new : dvd_new;
    r_fix      = neg_r ? -rem_new : rem_new;
    fin_result = rem_sel ? r_fix : q_fix;

    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fast ? FIN : CALC;
      CALC:    if (calc_flush) state_nxt = IDLE;
               else if (cnt == '0) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      rem_sel     <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      calc_result <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          rem_sel <= calc_para[1];
          neg_q   <= sign0 ^ sign1;
          neg_r   <= sign0;
          dvd     <= abs0;
          dvs     <= abs1;
          rem     <= '0;
          cnt     <= CNT_W'(XLEN-1);
          if (fast) calc_result <= fast_result;
        end
        CALC: if (!calc_flush) begin
          rem <= rem_new;
          dvd <= dvd_new;
          if (cnt == '0) calc_result <= fin_result;
          else           cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign calc_busy = (state != IDLE);
  assign calc_done = (state == FIN);

endmodule

// File: tb/tb_rv3n_func_div.sv
// Scoreboard bench for rv3n_func_div: stimulus pushes expected results and done cycles, a negedge monitor checks them.
module tb_rv3n_func_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        calc_valid;
  logic [7:0]  calc_para;
  logic [31:0] calc_operand0, calc_operand1;
  logic        calc_flush;
  logic        calc_busy, calc_done;
  logic [31:0] calc_result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  localparam logic [7:0] P_DIV = 8'h04, P_DIVU = 8'h05, P_REM = 8'h06, P_REMU = 8'h07;

  rv3n_func_div #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .calc_valid(calc_valid), .calc_para(calc_para),
    .calc_operand0(calc_operand0), .calc_operand1(calc_operand1), .calc_flush(calc_flush),
    .calc_busy(calc_busy), .calc_done(calc_done), .calc_result(calc_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected entry in value and cycle.
  always @(negedge clk) begin
    if (calc_done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", calc_result, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", calc_result, e.res);
        check("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // One-cycle request in the current cycle; returns 1ns into the following cycle.
  task automatic issue(input logic [7:0] para, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] res, input int lat);
    @(negedge clk);
    calc_valid    = 1'b1;
    calc_para     = para;
    calc_operand0 = a;
    calc_operand1 = b;
    if (push) sb.push_back('{res: res, cyc: cyc + lat});
    @(posedge clk);
    #1;
    calc_valid    = 1'b0;
    calc_operand0 = $urandom;
    calc_operand1 = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (calc_busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_reached", {31'b0, calc_busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; calc_valid = 1'b0; calc_para = '0; calc_flush = 1'b0;
    calc_operand0 = '0; calc_operand1 = '0;
    #12;
    check("rst_busy", {31'b0, calc_busy}, 32'd0);
    check("rst_done", {31'b0, calc_done}, 32'd0);
    check("rst_result", calc_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Normal path with busy window 1..33.
    issue(P_DIV, 32'd100, 32'd7, 1, 32'd14, 33);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      check("div_busy_window", {31'b0, calc_busy}, 32'd1);
    end
    @(negedge clk);
    check("div_busy_after", {31'b0, calc_busy}, 32'd0);

    issue(P_REM,  32'hFFFF_FFF9, 32'd2,  1, 32'hFFFF_FFFF, 33); wait_idle();
    issue(P_DIVU, 32'hFFFF_FFFF, 32'h10, 1, 32'h0FFF_FFFF, 33); wait_idle();
    issue(P_REMU, 32'hFFFF_FFFF, 32'h10, 1, 32'h0000_000F, 33); wait_idle();
    issue(P_DIV,  32'hFFFF_FF9C, 32'd7,  1, 32'hFFFF_FFF2, 33); wait_idle();

    // Fast paths.
    issue(P_DIVU, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 1); wait_idle();
    issue(P_REM,  32'd5, 32'd0, 1, 32'd5, 1);         wait_idle();
    issue(P_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 1);        wait_idle();
    issue(P_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1); wait_idle();

    // Flush at cycle 10 of a DIV, then DIVU 9/3 issued at cycle 11.
    issue(P_DIV, 32'd100, 32'd7, 0, 32'd0, 0);
    repeat (9) @(posedge clk);
    #1 calc_flush = 1'b1;
    @(posedge clk);
    #1 calc_flush = 1'b0;
    check("flush_busy", {31'b0, calc_busy}, 32'd0);
    check("flush_result_held", calc_result, 32'h8000_0000);
    issue(P_DIVU, 32'd9, 32'd3, 1, 32'd3, 33);
    wait_idle();

    // Request while busy is ignored.
    issue(P_DIV, 32'd100, 32'd7, 1, 32'd14, 33);
    repeat (4) @(posedge clk);
    issue(P_REMU, 32'd10, 32'd3, 0, 32'd0, 0);
    wait_idle();
    repeat (3) @(posedge clk);

    // Non-divide funct3 is ignored.
    issue(8'h03, 32'd10, 32'd3, 0, 32'd0, 0);
    check("para03_busy", {31'b0, calc_busy}, 32'd0);
    @(negedge clk);
    check("para03_done", {31'b0, calc_done}, 32'd0);

    // Back-to-back: request in FIN ignored, request one cycle later accepted.
    issue(P_DIVU, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 1);
    issue(P_DIVU, 32'd8, 32'd2, 0, 32'd0, 0);
    issue(P_REMU, 32'd7, 32'd0, 1, 32'd7, 1);
    wait_idle();

    // Async reset mid-CALC, between edges.
    issue(P_DIV, 32'd100, 32'd7, 0, 32'd0, 0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_busy", {31'b0, calc_busy}, 32'd0);
    check("async_rst_done", {31'b0, calc_done}, 32'd0);
    check("async_rst_result", calc_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(P_REMU, 32'd10, 32'd3, 1, 32'd1, 33);
    wait_idle();

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
